// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad constants and the buffered event record
package keypad_pkg;
  localparam int KEY_NUM = 16;
  localparam int KEYCODE_W = 4;
  typedef struct packed {
    logic [KEYCODE_W-1:0] code;
    logic press;
    logic rpt;
  } evt_t;
  localparam int EVT_W = $bits(evt_t);
endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: first-word-fall-through event FIFO with a registered head; clk/rst, wr/din in, rd/dout/valid/full out, DEPTH counts the head entry
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [EVT_W-1:0] din,
  input  logic             rd,
  output logic [EVT_W-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, ram_cnt;
  logic take, load;
  assign ram_cnt = wp - rp;
  assign take = valid & rd;
  assign load = |ram_cnt & (~valid | take);
  assign full = (ram_cnt + (AW+1)'(valid)) == (AW+1)'(DEPTH);
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      valid <= 1'b0;
      dout <= '0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (load) begin
        rp <= rp + (AW+1)'(1);
        dout <= mem[rp[AW-1:0]];
      end
      valid <= load | (valid & ~take);
    end
endmodule

// File: rtl/keypad_event_decoder.sv
// keypad_event_decoder: debounces a 16-key active-low map, emits buffered press/release keycode events (auto-repeat when KEYPAD_AUTOREPEAT_EN is defined)
module keypad_event_decoder
  import keypad_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int DEBOUNCE_CNT = 10,
  parameter int FIFO_DEPTH = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE = 100
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_NUM-1:0]   key_raw,
  output logic [KEY_NUM-1:0]   key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEYCODE_W-1:0] evt_code,
  output logic                 evt_press,
  output logic                 evt_repeat,
  output logic                 evt_overflow
);
  localparam int PW = $clog2(SAMPLE_DIV);
  logic [PW-1:0] presc;
  logic tick;
  logic [7:0] cnt [KEY_NUM];
  logic [KEY_NUM-1:0] reported, pending;
  logic [KEYCODE_W-1:0] low;
  logic full, rd, room, edge_wr, wr;
  evt_t din, head, edge_evt;
  assign tick = presc == PW'(SAMPLE_DIV-1);
  always_ff @(posedge clk)
    presc <= (rst || tick) ? '0 : presc + PW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      key_state <= '0;
      for (int i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < KEY_NUM; i++)
        if (key_raw[i] != key_state[i]) cnt[i] <= '0;
        else if (cnt[i] == 8'(DEBOUNCE_CNT-1)) begin
          key_state[i] <= ~key_state[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 8'd1;
    end
  assign pending = key_state ^ reported;
  always_comb begin
    low = '0;
    for (int i = KEY_NUM-1; i >= 0; i--) if (pending[i]) low = KEYCODE_W'(i);
  end
  assign rd = evt_valid & evt_ready;
  assign room = ~full | rd;
  assign edge_wr = |pending & room;
  assign edge_evt = evt_t'{code: low, press: key_state[low], rpt: 1'b0};
  always_ff @(posedge clk)
    if (rst) begin
      reported <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (edge_wr) reported[low] <= key_state[low];
      if (|pending && !room) evt_overflow <= 1'b1;
    end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [KEYCODE_W-1:0] target;
  logic [RW-1:0] timer;
  logic armed, in_delay, rpt_req, held, rpt_wr;
  assign held = armed & key_state[target];
  assign rpt_wr = ~|pending & rpt_req & held & room;
  assign wr = edge_wr | rpt_wr;
  assign din = edge_wr ? edge_evt : evt_t'{code: target, press: 1'b1, rpt: 1'b1};
  always_ff @(posedge clk)
    if (rst) begin
      target <= '0;
      timer <= '0;
      armed <= 1'b0;
      in_delay <= 1'b0;
      rpt_req <= 1'b0;
    end else if (edge_wr && key_state[low]) begin
      target <= low;
      timer <= '0;
      armed <= 1'b1;
      in_delay <= 1'b1;
      rpt_req <= 1'b0;
    end else if (!held) begin
      timer <= '0;
      armed <= 1'b0;
      rpt_req <= 1'b0;
    end else begin
      if (rpt_wr) rpt_req <= 1'b0;
      if (tick) begin
        if (timer == RW'((in_delay ? REPEAT_DELAY : REPEAT_RATE) - 1)) begin
          timer <= '0;
          in_delay <= 1'b0;
          rpt_req <= 1'b1;
        end else timer <= timer + RW'(1);
      end
    end
`else
  assign wr = edge_wr;
  assign din = edge_evt;
`endif
  keypad_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .din(din),
    .rd(rd),
    .dout(head),
    .valid(evt_valid),
    .full(full)
  );
  assign evt_code = head.code;
  assign evt_press = head.press;
  assign evt_repeat = head.rpt;
endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb_keypad_event_decoder: directed stimulus with an expected-event queue checked by a handshake monitor
module tb_keypad_event_decoder;
  typedef struct packed {
    logic [3:0] code;
    logic press;
    logic rpt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] key_raw = 16'hFFFF;
  logic [15:0] key_state;
  logic evt_valid, evt_ready, evt_press, evt_repeat, evt_overflow;
  logic [3:0] evt_code;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  keypad_event_decoder #(
    .SAMPLE_DIV(4),
    .DEBOUNCE_CNT(3),
    .FIFO_DEPTH(4)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_raw(key_raw),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_press(evt_press),
    .evt_repeat(evt_repeat),
    .evt_overflow(evt_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  task automatic push(input logic [3:0] code, input logic press, input logic rpt);
    exp_q.push_back(exp_t'{code: code, press: press, rpt: rpt});
  endtask
  always @(negedge clk)
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got code=%0d press=%0b repeat=%0b, required none", evt_code, evt_press, evt_repeat);
      end else begin
        mon_e = exp_q.pop_front();
        if ({evt_code, evt_press, evt_repeat} !== mon_e) begin
          errors++;
          $display("FAIL event: got code=%0d press=%0b repeat=%0b, required code=%0d press=%0b repeat=%0b",
                   evt_code, evt_press, evt_repeat, mon_e.code, mon_e.press, mon_e.rpt);
        end
      end
    end
  initial begin
    evt_ready = 1'b1;
    step(3);
    chk("reset_key_state", 32'(key_state), 32'h0);
    chk("reset_evt_valid", 32'(evt_valid), 32'h0);
    chk("reset_evt_code", 32'(evt_code), 32'h0);
    chk("reset_evt_press", 32'(evt_press), 32'h0);
    chk("reset_evt_repeat", 32'(evt_repeat), 32'h0);
    chk("reset_evt_overflow", 32'(evt_overflow), 32'h0);
    rst = 1'b0;
    step(100);
    chk("idle_key_state", 32'(key_state), 32'h0);
    do_reset();
    key_raw = 16'hFFDF;
    push(4'd5, 1'b1, 1'b0);
    step(11);
    chk("press_before_3rd_tick", 32'(key_state), 32'h0);
    step(1);
    chk("press_on_3rd_tick", 32'(key_state), 32'h0020);
    step(1);
    chk("press_valid_t1", 32'(evt_valid), 32'h0);
    step(1);
    chk("press_valid_t2", 32'(evt_valid), 32'h1);
    chk("press_code_t2", 32'(evt_code), 32'h5);
    key_raw = 16'hFFFF;
    push(4'd5, 1'b0, 1'b0);
    step(20);
    chk("release_key_state", 32'(key_state), 32'h0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key_raw = i[0] ? 16'hFFFF : 16'hFFDF;
      step(4);
    end
    key_raw = 16'hFFFF;
    step(20);
    chk("bounce_key_state", 32'(key_state), 32'h0);
    do_reset();
    key_raw = 16'h7FFE;
    push(4'd0, 1'b1, 1'b0);
    push(4'd15, 1'b1, 1'b0);
    step(14);
    chk("simul_first_valid", 32'(evt_valid), 32'h1);
    chk("simul_first_code", 32'(evt_code), 32'h0);
    step(1);
    chk("simul_second_valid", 32'(evt_valid), 32'h1);
    chk("simul_second_code", 32'(evt_code), 32'hF);
    key_raw = 16'hFFFF;
    push(4'd0, 1'b0, 1'b0);
    push(4'd15, 1'b0, 1'b0);
    step(30);
    do_reset();
    evt_ready = 1'b0;
    key_raw = 16'hFFF1;
    push(4'd1, 1'b1, 1'b0);
    push(4'd2, 1'b1, 1'b0);
    push(4'd3, 1'b1, 1'b0);
    step(19);
    chk("bp_no_overflow_yet", 32'(evt_overflow), 32'h0);
    key_raw = 16'hFFFF;
    push(4'd1, 1'b0, 1'b0);
    push(4'd2, 1'b0, 1'b0);
    push(4'd3, 1'b0, 1'b0);
    step(20);
    chk("bp_overflow", 32'(evt_overflow), 32'h1);
    chk("bp_valid", 32'(evt_valid), 32'h1);
    chk("bp_head", 32'({evt_code, evt_press}), 32'({4'd1, 1'b1}));
    chk("bp_key_state", 32'(key_state), 32'h0);
    evt_ready = 1'b1;
    step(20);
    chk("bp_overflow_sticky", 32'(evt_overflow), 32'h1);
    do_reset();
    chk("rst_clears_overflow", 32'(evt_overflow), 32'h0);
`ifdef KEYPAD_AUTOREPEAT_EN
    key_raw = 16'hFDFF;
    push(4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(4'd9, 1'b1, 1'b1);
    push(4'd9, 1'b0, 1'b0);
    step(50);
    key_raw = 16'hFFFF;
    step(40);
    chk("rpt_key_state", 32'(key_state), 32'h0);
`endif
    step(10);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
